// File: rtl/elelock_param.sv
// Parametrised electronic-lock controller: code entry, failed-attempt lockout, auto-relock.
// Optional code change in OPEN is built when ELELOCK_CODE_CHANGE_EN is defined.
module elelock_param #(
   parameter int                      CODE_LEN     = 4,
   parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 'h1234,
   parameter int                      MAX_FAIL     = 3,
   parameter int                      LOCKOUT_SEC  = 10,
   parameter int                      AUTO_SEC     = 5,
   parameter int                      TICK_HZ      = 32
) (
   input  logic                    ck,
   input  logic                    resetn,
   input  logic                    tick,
   input  logic [3:0]              keycode,
   input  logic                    keyenbl,
   output logic                    lock,
   output logic [4*CODE_LEN-1:0]   digits,
   output logic [CODE_LEN-1:0]     dispen,
   output logic [2:0]              state,
   output logic [3:0]              fail_cnt
);

   // state    | meaning
   // LOCKED   | idle, locked, display blank
   // ENTRY    | collecting code digits
   // OPEN     | unlocked, auto-relock timer running
   // LOCKOUT  | too many failures, keys ignored until timer expires
   // CHG1     | collecting new code (code-change build only)
   // CHG2     | collecting confirmation of new code (code-change build only)
   typedef enum logic [2:0] {
      S_LOCKED  = 3'd0,
      S_ENTRY   = 3'd1,
      S_OPEN    = 3'd2,
      S_LOCKOUT = 3'd3,
      S_CHG1    = 3'd4,
      S_CHG2    = 3'd5
   } state_t;

   localparam int DW          = 4 * CODE_LEN;
   localparam int CW          = $clog2(CODE_LEN + 1);
   localparam int LOCK_TICKS  = LOCKOUT_SEC * TICK_HZ;
   localparam int AUTO_TICKS  = AUTO_SEC * TICK_HZ;
   localparam int MAX_TICKS   = (LOCK_TICKS > AUTO_TICKS) ? LOCK_TICKS : AUTO_TICKS;
   localparam int TW          = $clog2(MAX_TICKS + 1);

   localparam logic [TW-1:0] LOCK_LD  = TW'(LOCK_TICKS);
   localparam logic [TW-1:0] AUTO_LD  = TW'(AUTO_TICKS);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CODE_LEN);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAIL);

   state_t            state_q, state_n;
   logic [DW-1:0]     buf_q, buf_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic [DW-1:0]     code_q, code_n;
   logic [3:0]        fail_q, fail_n;
   logic [TW-1:0]     tmr_q, tmr_n;
   logic              lock_q, lock_n;
   logic [DW-1:0]     digits_q, digits_n;
   logic [CODE_LEN-1:0] dispen_q, dispen_n;
`ifdef ELELOCK_CODE_CHANGE_EN
   logic [DW-1:0]     cand_q, cand_n;
`endif

   logic              is_dig, is_clr, is_ent;
   logic              tmr_tc;
   logic              entry_full;
   logic [DW-1:0]     buf_shift;
   logic [CW-1:0]     cnt_inc;
   logic [3:0]        fail_inc;
   logic [CODE_LEN-1:0] entry_en;

   assign is_dig     = keyenbl && (keycode <= 4'd9);
   assign is_clr     = keyenbl && (keycode == 4'hA);
   assign is_ent     = keyenbl && (keycode == 4'hB);
   // terminal count of the down-counter; a zero load never expires
   assign tmr_tc     = tick && (tmr_q == TMR_ONE);
   assign entry_full = (cnt_q == CNT_FULL);
   assign cnt_inc    = entry_full ? cnt_q : cnt_q + CNT_ONE;
   assign fail_inc   = fail_q + 4'd1;

   generate
      if (CODE_LEN > 1) begin : g_shift
         assign buf_shift = {buf_q[DW-5:0], keycode};
      end else begin : g_noshift
         assign buf_shift = keycode;
      end
   endgenerate

   always_ff @(posedge ck or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_LOCKED;
         buf_q    <= '0;
         cnt_q    <= '0;
         code_q   <= DEFAULT_CODE;
         fail_q   <= '0;
         tmr_q    <= '0;
         lock_q   <= 1'b1;
         digits_q <= '0;
         dispen_q <= '0;
`ifdef ELELOCK_CODE_CHANGE_EN
         cand_q   <= '0;
`endif
      end else begin
         state_q  <= state_n;
         buf_q    <= buf_n;
         cnt_q    <= cnt_n;
         code_q   <= code_n;
         fail_q   <= fail_n;
         tmr_q    <= tmr_n;
         lock_q   <= lock_n;
         digits_q <= digits_n;
         dispen_q <= dispen_n;
`ifdef ELELOCK_CODE_CHANGE_EN
         cand_q   <= cand_n;
`endif
      end
   end

   always_comb begin
      state_n = state_q;
      buf_n   = buf_q;
      cnt_n   = cnt_q;
      code_n  = code_q;
      fail_n  = fail_q;
      tmr_n   = (tick && (tmr_q != '0)) ? tmr_q - TMR_ONE : tmr_q;
`ifdef ELELOCK_CODE_CHANGE_EN
      cand_n  = cand_q;
`endif
      case (state_q)
         S_LOCKED: begin
            if (is_dig) begin
               state_n = S_ENTRY;
               buf_n   = DW'(keycode);
               cnt_n   = CNT_ONE;
            end
         end
         S_ENTRY: begin
            if (is_dig) begin
               buf_n = buf_shift;
               cnt_n = cnt_inc;
            end else if (is_clr) begin
               state_n = S_LOCKED;
               buf_n   = '0;
               cnt_n   = '0;
            end else if (is_ent) begin
               buf_n = '0;
               cnt_n = '0;
               if (entry_full && (buf_q == code_q)) begin
                  state_n = S_OPEN;
                  fail_n  = '0;
                  tmr_n   = AUTO_LD;
               end else begin
                  fail_n = fail_inc;
                  if (fail_inc == FAIL_MAX) begin
                     state_n = S_LOCKOUT;
                     tmr_n   = LOCK_LD;
                  end else begin
                     state_n = S_LOCKED;
                  end
               end
            end
         end
         S_OPEN: begin
            if (keyenbl) begin
               tmr_n = AUTO_LD;
               if (is_ent) begin
                  state_n = S_LOCKED;
                  tmr_n   = '0;
               end
`ifdef ELELOCK_CODE_CHANGE_EN
               else if (is_clr) begin
                  state_n = S_CHG1;
                  buf_n   = '0;
                  cnt_n   = '0;
               end
`endif
            end else if (tmr_tc) begin
               state_n = S_LOCKED;
            end
         end
         S_LOCKOUT: begin
            if (tmr_tc) begin
               state_n = S_LOCKED;
               fail_n  = '0;
            end
         end
`ifdef ELELOCK_CODE_CHANGE_EN
         S_CHG1, S_CHG2: begin
            if (keyenbl) begin
               tmr_n = AUTO_LD;
               if (is_dig) begin
                  buf_n = buf_shift;
                  cnt_n = cnt_inc;
               end else if (is_clr) begin
                  state_n = S_OPEN;
                  buf_n   = '0;
                  cnt_n   = '0;
               end else if (is_ent) begin
                  buf_n   = '0;
                  cnt_n   = '0;
                  state_n = S_OPEN;
                  if (state_q == S_CHG1) begin
                     if (entry_full) begin
                        cand_n  = buf_q;
                        state_n = S_CHG2;
                     end
                  end else if (entry_full && (buf_q == cand_q)) begin
                     code_n = cand_q;
                  end
               end
            end else if (tmr_tc) begin
               // relock mid-change throws away the partial new code
               state_n = S_LOCKED;
               buf_n   = '0;
               cnt_n   = '0;
            end
         end
`endif
         default: begin
            state_n = S_LOCKED;
            buf_n   = '0;
            cnt_n   = '0;
            tmr_n   = '0;
         end
      endcase
   end

   always_comb begin
      entry_en = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         entry_en[i] = (i < int'(cnt_n));
      end
      lock_n   = 1'b1;
      digits_n = '0;
      dispen_n = '0;
      case (state_n)
         S_ENTRY: begin
            digits_n = buf_n;
            dispen_n = entry_en;
         end
         S_OPEN: begin
            lock_n = 1'b0;
         end
         S_LOCKOUT: begin
            digits_n = {CODE_LEN{4'hE}};
            dispen_n = '1;
         end
`ifdef ELELOCK_CODE_CHANGE_EN
         S_CHG1, S_CHG2: begin
            lock_n   = 1'b0;
            digits_n = buf_n;
            dispen_n = entry_en;
         end
`endif
         default: begin
         end
      endcase
   end

   assign lock     = lock_q;
   assign digits   = digits_q;
   assign dispen   = dispen_q;
   assign state    = state_q;
   assign fail_cnt = fail_q;

endmodule

// File: tb/tb_elelock_param.sv
// Directed bench for elelock_param with a queue-based lock model checked every cycle.
module tb_elelock_param;

   localparam int CL       = 4;
   localparam int MAXF     = 3;
   localparam int LOCKS    = 10;
   localparam int AUTOS    = 5;
   localparam int HZ       = 32;
`ifdef ELELOCK_CODE_CHANGE_EN
   localparam bit CHG      = 1'b1;
`else
   localparam bit CHG      = 1'b0;
`endif

   logic            ck = 1'b0;
   logic            resetn = 1'b1;
   logic            tick = 1'b0;
   logic [3:0]      keycode = 4'h0;
   logic            keyenbl = 1'b0;
   logic            lock;
   logic [4*CL-1:0] digits;
   logic [CL-1:0]   dispen;
   logic [2:0]      state;
   logic [3:0]      fail_cnt;

   elelock_param #(
      .CODE_LEN(CL), .DEFAULT_CODE(16'h1234), .MAX_FAIL(MAXF),
      .LOCKOUT_SEC(LOCKS), .AUTO_SEC(AUTOS), .TICK_HZ(HZ)
   ) dut (
      .ck(ck), .resetn(resetn), .tick(tick), .keycode(keycode), .keyenbl(keyenbl),
      .lock(lock), .digits(digits), .dispen(dispen), .state(state), .fail_cnt(fail_cnt)
   );

   always #5 ck = ~ck;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // model: state code, entered digits in order, counters in plain ticks
   int m_st;
   int q[$];
   int m_code[$];
   int m_cand[$];
   int m_fail;
   int m_idle;
   int m_lt;

   function automatic bit same(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_st = 0; q.delete(); m_fail = 0; m_idle = 0; m_lt = 0;
      m_code.delete();
      m_code.push_back(1); m_code.push_back(2); m_code.push_back(3); m_code.push_back(4);
      m_cand.delete();
   endtask

   task automatic push_digit(input int d);
      q.push_back(d);
      if (q.size() > CL) void'(q.pop_front());
   endtask

   task automatic model_step(input bit t, input bit ke, input int kc);
      bit dig, clr, ent;
      dig = ke && (kc <= 9);
      clr = ke && (kc == 10);
      ent = ke && (kc == 11);
      case (m_st)
         0: if (dig) begin q.delete(); q.push_back(kc); m_st = 1; end
         1: begin
            if (dig) push_digit(kc);
            else if (clr) begin q.delete(); m_st = 0; end
            else if (ent) begin
               if (q.size() == CL && same(q, m_code)) begin
                  m_st = 2; m_fail = 0; m_idle = 0;
               end else begin
                  m_fail++;
                  if (m_fail == MAXF) begin m_st = 3; m_lt = 0; end
                  else m_st = 0;
               end
               q.delete();
            end
         end
         2: begin
            if (ke) begin
               m_idle = 0;
               if (ent) m_st = 0;
               else if (CHG && clr) begin m_st = 4; q.delete(); end
            end else if (t) begin
               m_idle++;
               if (AUTOS > 0 && m_idle == AUTOS * HZ) m_st = 0;
            end
         end
         3: if (t) begin
            m_lt++;
            if (m_lt == LOCKS * HZ) begin m_st = 0; m_fail = 0; end
         end
         4, 5: begin
            if (ke) begin
               m_idle = 0;
               if (dig) push_digit(kc);
               else if (clr) begin m_st = 2; q.delete(); end
               else if (ent) begin
                  if (m_st == 4 && q.size() == CL) begin m_cand = q; m_st = 5; end
                  else begin
                     if (m_st == 5 && q.size() == CL && same(q, m_cand)) m_code = m_cand;
                     m_st = 2;
                  end
                  q.delete();
               end
            end else if (t) begin
               m_idle++;
               if (AUTOS > 0 && m_idle == AUTOS * HZ) begin m_st = 0; q.delete(); end
            end
         end
         default: m_st = 0;
      endcase
   endtask

   function automatic logic [4*CL-1:0] exp_digits();
      logic [4*CL-1:0] v;
      int d;
      v = '0;
      if (m_st == 3) v = {CL{4'hE}};
      else if (m_st == 1 || m_st == 4 || m_st == 5)
         for (int i = 0; i < q.size(); i++) begin
            d = q[q.size() - 1 - i];
            v[4*i +: 4] = d[3:0];
         end
      return v;
   endfunction

   function automatic logic [CL-1:0] exp_dispen();
      logic [CL-1:0] v;
      v = '0;
      if (m_st == 3) v = '1;
      else if (m_st == 1 || m_st == 4 || m_st == 5)
         for (int i = 0; i < q.size(); i++) v[i] = 1'b1;
      return v;
   endfunction

   always @(negedge ck) begin
      if (chk_en) begin
         logic            e_lock;
         logic [4*CL-1:0] e_dig;
         logic [CL-1:0]   e_en;
         e_lock = !(m_st == 2 || m_st == 4 || m_st == 5);
         e_dig  = exp_digits();
         e_en   = exp_dispen();
         n_vec++;
         if (lock !== e_lock || digits !== e_dig || dispen !== e_en ||
             state !== 3'(m_st) || fail_cnt !== 4'(m_fail)) begin
            n_err++;
            $display("FAIL model t=%0t got lock=%b dig=%h en=%b st=%0d fail=%0d want lock=%b dig=%h en=%b st=%0d fail=%0d",
                     $time, lock, digits, dispen, state, fail_cnt, e_lock, e_dig, e_en, m_st, m_fail);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit t, input bit ke, input logic [3:0] kc);
      tick = t; keyenbl = ke; keycode = kc;
      @(posedge ck);
      #1;
      model_step(t, ke, int'(kc));
      tick = 1'b0; keyenbl = 1'b0;
   endtask

   task automatic key(input logic [3:0] k);
      cyc(1'b0, 1'b1, k);
      cyc(1'b0, 1'b0, 4'h0);
   endtask

   task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      key(a); key(b); key(c); key(d);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 4'h0);
         cyc(1'b0, 1'b0, 4'h0);
      end
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      model_reset();
      @(posedge ck);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      #2 resetn = 1'b0;
      model_reset();
      #20;
      @(posedge ck);
      #1;
      resetn = 1'b1;
      chk_en = 1'b1;
      chk("rst_state", int'(state), 0);
      chk("rst_lock", int'(lock), 1);
      chk("rst_digits", int'(digits), 0);
      chk("rst_dispen", int'(dispen), 0);
      chk("rst_fail", int'(fail_cnt), 0);

      // T1
      key(4'h1); key(4'h2);
      chk("t1_digits", int'(digits), 'h0012);
      chk("t1_dispen", int'(dispen), 'b0011);
      key(4'h3); key(4'h4); key(4'hB);
      chk("t1_lock", int'(lock), 0);
      chk("t1_state", int'(state), 2);
      chk("t1_fail", int'(fail_cnt), 0);
`ifndef ELELOCK_CODE_CHANGE_EN
      key(4'hA);
      chk("open_clr_ignored", int'(state), 2);
`endif

      // T2: overflow with an ignored key in the middle
      key(4'hB);
      chk("t2_relock", int'(lock), 1);
      key(4'h9); key(4'h1); key(4'hF); key(4'h2); key(4'h3); key(4'h4);
      chk("t2_digits", int'(digits), 'h1234);
      chk("t2_dispen", int'(dispen), 'b1111);
      key(4'hB);
      chk("t2_lock", int'(lock), 0);

      // T3: lockout
      key(4'hB);
      for (int n = 1; n <= MAXF; n++) begin
         code4(4'h1, 4'h1, 4'h1, 4'h1);
         key(4'hB);
         chk("t3_fail", int'(fail_cnt), n);
      end
      chk("t3_state", int'(state), 3);
      chk("t3_digits", int'(digits), 'hEEEE);
      code4(4'h1, 4'h2, 4'h3, 4'h4);
      key(4'hB);
      ticks(319);
      chk("t3_still_out", int'(state), 3);
      cyc(1'b1, 1'b0, 4'h0);
      chk("t3_exit_state", int'(state), 0);
      chk("t3_exit_fail", int'(fail_cnt), 0);

      // T4: auto-relock, then restart by a key at tick 100
      code4(4'h1, 4'h2, 4'h3, 4'h4); key(4'hB);
      ticks(159);
      chk("t4_open_159", int'(lock), 0);
      cyc(1'b1, 1'b0, 4'h0);
      chk("t4_relock_160", int'(lock), 1);
      code4(4'h1, 4'h2, 4'h3, 4'h4); key(4'hB);
      ticks(99);
      cyc(1'b1, 1'b1, 4'h5);
      cyc(1'b0, 1'b0, 4'h0);
      ticks(159);
      chk("t4_restart_open", int'(lock), 0);
      cyc(1'b1, 1'b0, 4'h0);
      chk("t4_restart_lock", int'(lock), 1);

      // T5: CLR mid-entry, then reset while open
      key(4'h1); key(4'h2); key(4'hA);
      chk("t5_clr_state", int'(state), 0);
      code4(4'h1, 4'h2, 4'h3, 4'h4); key(4'hB);
      chk("t5_open", int'(lock), 0);
      pulse_reset();
      chk("t5_rst_lock", int'(lock), 1);
      chk("t5_rst_digits", int'(digits), 0);

`ifdef ELELOCK_CODE_CHANGE_EN
      // T6: change code to 5678
      code4(4'h1, 4'h2, 4'h3, 4'h4); key(4'hB);
      key(4'hA);
      chk("t6_chg1", int'(state), 4);
      code4(4'h5, 4'h6, 4'h7, 4'h8); key(4'hB);
      chk("t6_chg2", int'(state), 5);
      code4(4'h5, 4'h6, 4'h7, 4'h8); key(4'hB);
      chk("t6_back_open", int'(state), 2);
      key(4'hB);
      code4(4'h5, 4'h6, 4'h7, 4'h8); key(4'hB);
      chk("t6_new_code", int'(lock), 0);
      key(4'hB);
      code4(4'h1, 4'h2, 4'h3, 4'h4); key(4'hB);
      chk("t6_old_fails", int'(fail_cnt), 1);
`endif

      cyc(1'b0, 1'b0, 4'h0);
      @(posedge ck);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
